eta_error_monitor: RTL
======================

# eta_error_monitor

Sequential error-characterisation unit for the approximate-adder family. It accepts a stream of operand pairs together with the sum returned by an approximate adder under test. For each pair it recomputes the exact sum, forms the error distance (ED), and accumulates run statistics over a programmed number of samples: error count, ED sum and maximum ED. It is the checking end of the adder datapath and is used by the DNN framework's characterisation benches and on-chip error-profiling hooks.

## Interface
Parameters:
- BITWIDTH, 8, operand width; the approximate sum is BITWIDTH+1 bits.
- CNT_W, 16, width of the sample counter and of num_samples.
- ACC_W, 32, width of the ED-sum accumulator (ACC_W ≥ BITWIDTH+1).

Ports:
- clk  in  1  single clock, all state on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begins a run; sampled only in IDLE.
- num_samples  in  CNT_W  samples in the run; latched on start.
- in_valid  in  1  operand/approx tuple valid.
- in_ready  out  1  monitor accepts a tuple this cycle.
- a, b  in  BITWIDTH  operands.
- approx_sum  in  BITWIDTH+1  approximate adder result for a, b.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of run.
- sample_count  out  CNT_W  tuples accumulated in the current or last run.
- err_count  out  CNT_W  tuples with ED ≠ 0.
- sum_ed  out  ACC_W  sum of ED; saturates at all-ones.
- max_ed  out  BITWIDTH+1  largest ED seen.

## Operation
- Exact sum = zero-extended a + b, BITWIDTH+1 bits. ED = |exact − approx_sum|, unsigned, BITWIDTH+1 bits.
- A tuple is accepted on a rising edge where in_valid & in_ready.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: in_ready=0. On start with num_samples≠0: clear all statistics, load remaining=num_samples, go to RUN. On start with num_samples=0: clear statistics, go to DONE.
  - RUN: in_ready=1. Each accept decrements remaining. The accept that brings remaining to 0 moves the FSM to DRAIN. in_ready is low from that point on.
  - DRAIN: held exactly 2 cycles to empty the pipeline, then go to DONE.
  - DONE: done=1 for one cycle, then go to IDLE.
- start is ignored outside IDLE.
- Outputs hold their values after the run until the next accepted start.
- Saturation rules:
  - sum_ed clamps at 2^ACC_W−1 and never wraps.
  - sample_count and err_count cannot overflow, because they are bounded by num_samples.
- Reset (asynchronous, at any time including mid-run): state=IDLE, pipeline valids=0, in_ready=0, busy=0, done=0, all statistics=0. In-flight tuples are discarded.

## Timing
- Pipeline stage 1: registers a, b, approx_sum and a valid bit at the accept edge k.
- Pipeline stage 2: registers ED and a valid bit at edge k+1.
- Statistics update at edge k+2; the accept-to-statistics latency is 2 cycles.
- Throughput: one tuple per cycle in RUN.
- Last accept at edge k: DRAIN during cycles k..k+1, final statistics visible after edge k+2, done high during the cycle after edge k+2, busy low after edge k+3.
- Zero-sample run: done high the cycle after the start edge.

## Structure
- Shared package eta_pkg holds:
  - the FSM state typedef (IDLE/RUN/DRAIN/DONE);
  - the DRAIN_CYCLES=2 constant;
  - the ED function: exact add plus absolute difference.
- One sub-module, eta_ed_stage: the combinational exact-sum and |diff| logic feeding the stage-2 register. The FSM and accumulators stay in the top module.

## Test plan
- Reset mid-run: start N=10, assert rst after 4 accepts → all outputs 0, in_ready=0, state IDLE; a following start N=1 works normally.
- BITWIDTH=8, N=3, tuples (3,1,approx 3), (255,255,approx 510), (16,8,approx 20) → sample_count=3, err_count=2, sum_ed=5, max_ed=4, done a single pulse 3 cycles after the last accept.
- N=0 start → done the next cycle, all statistics 0, in_ready never high.
- Back-to-back valids with random in_valid gaps, N=1000 → sample_count=1000, and the statistics match a bench-side ETA-I reference model with BORDER=2.
- ACC_W=9, 3 tuples each with ED=256 → sum_ed saturates at 511, max_ed=256.
- Start pulses asserted during RUN and DRAIN → ignored; num_samples changes after the start edge have no effect.

Source files
------------

// File: rtl/eta_pkg.sv
// Shared types, constants and the error-distance function for the ETA error monitor.
// The ED function works at a fixed maximum width; callers zero-extend and truncate.
package eta_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int DRAIN_CYCLES = 2;
    localparam int ED_MAX_W     = 64;

    function automatic logic [ED_MAX_W:0] calc_ed(
        input logic [ED_MAX_W-1:0] a,
        input logic [ED_MAX_W-1:0] b,
        input logic [ED_MAX_W:0]   approx
    );
        logic [ED_MAX_W:0] exact;
        exact = {1'b0, a} + {1'b0, b};
        return (exact >= approx) ? (exact - approx) : (approx - exact);
    endfunction

endpackage

// File: rtl/eta_error_monitor_ed_stage.sv
// Combinational exact sum and |exact - approx| feeding the stage-2 register.
// Zero latency, no flow control; valid for BITWIDTH < 64.
module eta_ed_stage
    import eta_pkg::*;
#(
    parameter int BITWIDTH = 8
) (
    input  logic [BITWIDTH-1:0] a,
    input  logic [BITWIDTH-1:0] b,
    input  logic [BITWIDTH:0]   approx_sum,
    output logic [BITWIDTH:0]   ed
);

    logic [ED_MAX_W:0] w_ed_full;
    logic              w_unused_hi;

    assign w_ed_full = calc_ed({{(ED_MAX_W-BITWIDTH){1'b0}}, a},
                               {{(ED_MAX_W-BITWIDTH){1'b0}}, b},
                               {{(ED_MAX_W-BITWIDTH){1'b0}}, approx_sum});

    // Operands are zero-extended, so the upper bits are always zero.
    assign w_unused_hi = ^w_ed_full[ED_MAX_W:BITWIDTH+1];
    assign ed          = w_ed_full[BITWIDTH:0];

endmodule

// File: rtl/eta_error_monitor.sv
// Error-statistics monitor for approximate adders: accept -> statistics latency 2 cycles,
// one tuple per cycle in RUN; in_ready drops after the last sample of a run.
module eta_error_monitor
    import eta_pkg::*;
#(
    parameter int BITWIDTH = 8,
    parameter int CNT_W    = 16,
    parameter int ACC_W    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [CNT_W-1:0]    num_samples,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BITWIDTH-1:0] a,
    input  logic [BITWIDTH-1:0] b,
    input  logic [BITWIDTH:0]   approx_sum,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    sample_count,
    output logic [CNT_W-1:0]    err_count,
    output logic [ACC_W-1:0]    sum_ed,
    output logic [BITWIDTH:0]   max_ed
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_remaining;
    logic [1:0]          r_drain_cnt;

    logic                r_s1_vld;
    logic [BITWIDTH-1:0] r_s1_a;
    logic [BITWIDTH-1:0] r_s1_b;
    logic [BITWIDTH:0]   r_s1_approx;
    logic                r_s2_vld;
    logic [BITWIDTH:0]   r_s2_ed;
    logic [BITWIDTH:0]   w_ed;

    logic [CNT_W-1:0]    r_sample_count;
    logic [CNT_W-1:0]    r_err_count;
    logic [ACC_W-1:0]    r_sum_ed;
    logic [BITWIDTH:0]   r_max_ed;
    logic [ACC_W:0]      w_sum_ext;

    logic                w_accept;
    logic                w_start_acc;
    logic                w_last;

    assign in_ready    = (r_state == ST_RUN);
    assign busy        = (r_state != ST_IDLE);
    assign done        = (r_state == ST_DONE);
    assign w_accept    = in_valid & in_ready;
    assign w_start_acc = (r_state == ST_IDLE) & start;
    assign w_last      = w_accept & (r_remaining == CNT_W'(1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = (num_samples != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (r_drain_cnt == 2'(DRAIN_CYCLES - 1)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_drain_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= (r_state == ST_DRAIN) ? r_drain_cnt + 2'd1 : 2'd0;
            if (w_start_acc) begin
                r_remaining <= num_samples;
            end else if (w_accept) begin
                r_remaining <= r_remaining - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_vld    <= 1'b0;
            r_s1_a      <= '0;
            r_s1_b      <= '0;
            r_s1_approx <= '0;
            r_s2_vld    <= 1'b0;
            r_s2_ed     <= '0;
        end else begin
            r_s1_vld <= w_accept;
            r_s2_vld <= r_s1_vld;
            r_s2_ed  <= w_ed;
            if (w_accept) begin
                r_s1_a      <= a;
                r_s1_b      <= b;
                r_s1_approx <= approx_sum;
            end
        end
    end

    eta_ed_stage #(
        .BITWIDTH (BITWIDTH)
    ) u_ed_stage (
        .a          (r_s1_a),
        .b          (r_s1_b),
        .approx_sum (r_s1_approx),
        .ed         (w_ed)
    );

    assign w_sum_ext = {1'b0, r_sum_ed} + {{(ACC_W-BITWIDTH){1'b0}}, r_s2_ed};

    // Clear has priority; the pipeline is always empty in IDLE anyway.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sample_count <= '0;
            r_err_count    <= '0;
            r_sum_ed       <= '0;
            r_max_ed       <= '0;
        end else if (w_start_acc) begin
            r_sample_count <= '0;
            r_err_count    <= '0;
            r_sum_ed       <= '0;
            r_max_ed       <= '0;
        end else if (r_s2_vld) begin
            r_sample_count <= r_sample_count + CNT_W'(1);
            if (r_s2_ed != '0) begin
                r_err_count <= r_err_count + CNT_W'(1);
            end
            r_sum_ed <= w_sum_ext[ACC_W] ? {ACC_W{1'b1}} : w_sum_ext[ACC_W-1:0];
            if (r_s2_ed > r_max_ed) begin
                r_max_ed <= r_s2_ed;
            end
        end
    end

    assign sample_count = r_sample_count;
    assign err_count    = r_err_count;
    assign sum_ed       = r_sum_ed;
    assign max_ed       = r_max_ed;

endmodule
